// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared Hamming(38,32) definitions used by the stream encoder and the
// downstream decoder: word widths, parity bit locations and the mapping of
// data bits onto codeword indices (index 0 = codeword position 1).
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int DATA_W = 32;
    localparam int CW_W   = 38;
    localparam int PAR_W  = 6;

    // Parity bits live at positions 2^k, i.e. indices 2^k - 1.
    localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15, 31};

    // Codeword index of data bit j: data fills every position that is not a
    // power of two, in ascending order.
    function automatic int data_idx(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) res = p - 1;
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_enc_stream_if.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream_if
// Input/output valid-ready streams of the Hamming encoder.
//   in_data/in_valid/in_ready    : raw 32-bit words into the encoder
//   out_code/out_valid/out_ready : 38-bit codewords out to the decoder stage
// Modports: slave = encoder view, master = producer/consumer (bench) view.
// -----------------------------------------------------------------------------
interface hamming_enc_stream_if;
    import hamming_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   out_code;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_code, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_code, out_valid
    );

endinterface

// File: rtl/hamming_par_gen.sv
// -----------------------------------------------------------------------------
// hamming_par_gen
// Combinational Hamming(38,32) encoder with even parity.
//   data_i [31:0] : raw data word
//   code_o [37:0] : codeword, index 0 = position 1
// -----------------------------------------------------------------------------
module hamming_par_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   code_o
);

    logic [CW_W-1:0] dcw;   // data bits scattered, parity slots still zero

    always_comb begin
        dcw = '0;
        for (int j = 0; j < DATA_W; j++) begin
            dcw[data_idx(j)] = data_i[j];
        end
    end

    // Parity k covers every position whose binary number has bit k set; the
    // parity slots are zero in dcw so they drop out of the sum naturally.
    always_comb begin
        logic par;
        code_o = dcw;
        for (int k = 0; k < PAR_W; k++) begin
            par = 1'b0;
            for (int i = 0; i < CW_W; i++) begin
                if (((i + 1) & (1 << k)) != 0) par = par ^ dcw[i];
            end
            code_o[PAR_IDX[k]] = par;
        end
    end

endmodule

// File: rtl/hamming_enc_stream.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream
// Streaming Hamming(38,32) encoder. Accepted words are encoded
// combinationally and written into a 2-entry FIFO whose head register drives
// out_code, so there is no combinational path from in_data to out_code.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave side of the in/out valid-ready streams
//   enc_cnt   : count of codewords delivered (wraps at 16 bits)
//   inj_en, inj_pos : error injection, only with HAMMING_ERR_INJECT_EN defined;
//                     flips codeword bit inj_pos (if <= 37) on accept.
// -----------------------------------------------------------------------------
module hamming_enc_stream
    import hamming_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hamming_enc_stream_if.slave  bus,
    output logic [15:0]          enc_cnt
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [5:0]           inj_pos
`endif
);

    logic [CW_W-1:0] code_c;
    logic [CW_W-1:0] code_wr;

    logic [CW_W-1:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q, cnt_d;
    logic            in_ready_q;
    logic [15:0]     enc_cnt_q;
    logic            push, pop;

    hamming_par_gen u_par_gen (
        .data_i (bus.in_data),
        .code_o (code_c)
    );

`ifdef HAMMING_ERR_INJECT_EN
    always_comb begin
        code_wr = code_c;
        if (inj_en && (inj_pos < 6'(CW_W))) begin
            code_wr = code_c ^ (CW_W'(1) << inj_pos);
        end
    end
`else
    assign code_wr = code_c;
`endif

    // out_valid is derived from occupancy, so pop can never underflow.
    assign push = bus.in_valid && in_ready_q;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            enc_cnt_q  <= 16'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= code_wr;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                enc_cnt_q <= enc_cnt_q + 16'd1;
            end
            cnt_q      <= cnt_d;
            // Registered copy of (occupancy < 2): never looks at out_ready
            // combinationally.
            in_ready_q <= (cnt_d < 2'd2);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_code  = mem_q[rd_ptr_q];
    assign enc_cnt       = enc_cnt_q;

endmodule

// File: tb/tb_hamming_enc_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_enc_stream
// Directed bench for hamming_enc_stream. Checks use a stand-alone syndrome
// decoder (XOR of the positions of all set bits) and data extraction.
// Define HAMMING_ERR_INJECT_EN to exercise the error-injection ports.
// -----------------------------------------------------------------------------
module tb_hamming_enc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] enc_cnt;
`ifdef HAMMING_ERR_INJECT_EN
    logic        inj_en;
    logic [5:0]  inj_pos;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    hamming_enc_stream_if bus ();

    hamming_enc_stream dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .enc_cnt (enc_cnt)
`ifdef HAMMING_ERR_INJECT_EN
        ,
        .inj_en  (inj_en),
        .inj_pos (inj_pos)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] syn(input logic [37:0] c);
        logic [5:0] s;
        s = 6'd0;
        for (int i = 0; i < 38; i++) begin
            if (c[i]) s = s ^ 6'(i + 1);
        end
        return s;
    endfunction

    function automatic logic [31:0] extract(input logic [37:0] c);
        logic [31:0] d;
        int j;
        d = 32'd0;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p - 1];
                j++;
            end
        end
        return d;
    endfunction

    logic [31:0] dvec [3];
    logic [37:0] cvec [3];
    logic [31:0] q [$];
    logic [37:0] held;
    logic [37:0] fixed;
    logic [5:0]  s;
    int          acc, pushed, popped, cyc;

    initial begin
        dvec = '{32'h0000_0001, 32'h0000_0002, 32'h8000_0000};
        cvec = '{38'h7, 38'h19, 38'h20_8000_000A};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en  = 1'b0;
        inj_pos = 6'd0;
`endif
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_enc_cnt",   64'(enc_cnt),       64'd0);
        chk("rst_out_code",  64'(bus.out_code),  64'd0);

        // Zero word, 1-cycle latency, pop bumps the counter
        bus.in_data  = 32'd0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("zero_valid", 64'(bus.out_valid), 64'd1);
        chk("zero_code",  64'(bus.out_code),  64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("zero_cnt",   64'(enc_cnt),       64'd1);
        chk("zero_empty", 64'(bus.out_valid), 64'd0);

        // out_ready on an empty FIFO does nothing
        step();
        chk("uflow_valid", 64'(bus.out_valid), 64'd0);
        chk("uflow_cnt",   64'(enc_cnt),       64'd1);

        // Hand-computed single-bit codewords
        for (int v = 0; v < 3; v++) begin
            bus.in_data  = dvec[v];
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            chk("vec_code", 64'(bus.out_code), 64'(cvec[v]));
            step();
        end

        // All-ones word decodes clean
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("ones_syn",  64'(syn(bus.out_code)),     64'd0);
        chk("ones_data", 64'(extract(bus.out_code)), 64'hFFFF_FFFF);
        step();
        chk("vec_cnt", 64'(enc_cnt), 64'd5);

        // Backpressure: 3 pushes against a blocked consumer
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        #1 acc += int'(bus.in_ready);
        step();
        bus.in_data = 32'hCAFE_F00D;
        #1 acc += int'(bus.in_ready);
        step();
        bus.in_data = 32'hDEAD_BEEF;
        #1;
        chk("bp_third_ready", 64'(bus.in_ready), 64'd0);
        acc += int'(bus.in_ready);
        step();
        bus.in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd2);
        held = bus.out_code;
        step();
        step();
        chk("bp_hold_code", 64'(bus.out_code), 64'(held));
        chk("bp_first",     64'(extract(bus.out_code)), 64'h1234_5678);
        chk("bp_first_syn", 64'(syn(bus.out_code)),     64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_second",     64'(extract(bus.out_code)), 64'hCAFE_F00D);
        chk("bp_second_syn", 64'(syn(bus.out_code)),     64'd0);
        step();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Streaming 1000 random words at full rate
        rst = 1'b1;
        step();
        rst = 1'b0;
        pushed = 0;
        popped = 0;
        cyc    = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = $urandom;
        while (popped < 1000 && cyc < 1200) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("str_syn",  64'(syn(bus.out_code)),     64'd0);
                chk("str_data", 64'(extract(bus.out_code)), 64'(q.pop_front()));
                popped++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                pushed++;
            end
            step();
            if (pushed == 1000) bus.in_valid = 1'b0;
            else bus.in_data = $urandom;
            cyc++;
        end
        chk("str_popped", 64'(popped),  64'd1000);
        chk("str_cycles", 64'(cyc),     64'd1001);
        chk("str_cnt",    64'(enc_cnt), 64'd1000);

        // Counter wrap: run to 0xFFFF, then one more pop
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (enc_cnt != 16'hFFFF && cyc < 70000) begin
            bus.in_data = 32'(cyc);
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("wrap_preload", 64'(enc_cnt),       64'hFFFF);
        chk("wrap_pending", 64'(bus.out_valid), 64'd1);
        step();
        chk("wrap_cnt",   64'(enc_cnt),       64'd0);
        chk("wrap_empty", 64'(bus.out_valid), 64'd0);

        // Reset with two words queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0BAD_CAFE;
        step();
        bus.in_data = 32'h1357_9BDF;
        step();
        bus.in_valid = 1'b0;
        chk("mid_full_valid", 64'(bus.out_valid), 64'd1);
        chk("mid_full_ready", 64'(bus.in_ready),  64'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_code",  64'(bus.out_code),  64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready),  64'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_stale", 64'(bus.out_valid), 64'd0);
        end
        chk("mid_cnt", 64'(enc_cnt), 64'd0);

`ifdef HAMMING_ERR_INJECT_EN
        // Error injection at a valid index, then an out-of-range index
        bus.out_ready = 1'b0;
        bus.in_data   = 32'hA5A5_A5A5;
        bus.in_valid  = 1'b1;
        inj_en  = 1'b1;
        inj_pos = 6'd20;
        step();
        bus.in_valid = 1'b0;
        inj_en = 1'b0;
        s = syn(bus.out_code);
        chk("inj_syn", 64'(s), 64'd21);
        fixed = bus.out_code;
        if (s != 6'd0) fixed[s - 6'd1] = ~fixed[s - 6'd1];
        chk("inj_fix", 64'(extract(fixed)), 64'hA5A5_A5A5);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        inj_en  = 1'b1;
        inj_pos = 6'd45;
        step();
        bus.in_valid = 1'b0;
        inj_en = 1'b0;
        chk("inj_oor_syn",  64'(syn(bus.out_code)),     64'd0);
        chk("inj_oor_data", 64'(extract(bus.out_code)), 64'hA5A5_A5A5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
